// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined SLL/SRL/SRA/ROL/ROR shifter with valid/ready handshake and side-band tag
module pipe_shifter #(
  parameter int WIDTH = 32,
  parameter int STAGES = 2,
  parameter int TAG_W = 5,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [2:0]       in_func,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero
);
  localparam int G = (SW + STAGES - 1) / STAGES;
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input int a, input logic [2:0] f, input logic s);
    return f == 3'b001 ? d << a :
           f == 3'b010 ? d >> a :
           f == 3'b011 ? (d >> a) | ({WIDTH{s}} << (WIDTH - a)) :
           f == 3'b100 ? (d << a) | (d >> (WIDTH - a)) :
           f == 3'b101 ? (d >> a) | (d << (WIDTH - a)) : d;
  endfunction
  logic adv;
  logic zf;
  assign adv = ~out_valid | out_ready;
  assign in_ready = adv;
  assign zf = in_func == 3'b000 || in_func[2:1] == 2'b11;
  for (genvar k = 0; k < STAGES; k++) begin : g
    localparam int LO = k * G < SW ? k * G : SW;
    localparam int HI = (k + 1) * G < SW ? (k + 1) * G : SW;
    logic v, s;
    logic [WIDTH-1:0] d;
    logic [SW-1:0] sh;
    logic [2:0] f;
    logic [TAG_W-1:0] t;
    logic pv, ps;
    logic [WIDTH-1:0] pd, nd;
    logic [SW-1:0] psh;
    logic [2:0] pf;
    logic [TAG_W-1:0] pt;
    if (k == 0) begin : src
      assign pv = in_valid;
      assign ps = in_data[WIDTH-1];
      assign pd = zf ? '0 : in_data;
      assign psh = in_shamt;
      assign pf = in_func;
      assign pt = in_tag;
    end else begin : src
      assign pv = g[k-1].v;
      assign ps = g[k-1].s;
      assign pd = g[k-1].d;
      assign psh = g[k-1].sh;
      assign pf = g[k-1].f;
      assign pt = g[k-1].t;
    end
    // this stage's group of binary steps, LSB first
    always_comb begin
      nd = pd;
      for (int i = LO; i < HI; i++) nd = psh[i] ? step(nd, 1 << i, pf, ps) : nd;
    end
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        s <= 1'b0;
        d <= '0;
        sh <= '0;
        f <= '0;
        t <= '0;
      end else begin
        if (flush) v <= 1'b0;
        else if (adv) v <= pv;
        if (adv) begin
          s <= ps;
          d <= nd;
          sh <= psh;
          f <= pf;
          t <= pt;
        end
      end
    end
  end
  assign out_valid = g[STAGES-1].v;
  assign out_data = out_valid ? g[STAGES-1].d : '0;
  assign out_tag = g[STAGES-1].t;
  assign out_zero = ~|out_data;
endmodule
